// File: rtl/bsg_arb_round_robin_hold.sv
// Round-robin arbiter with a registered one-hot grant held until yumi_i,
// then priority rotates past the last winner.
module bsg_arb_round_robin_hold #(
  parameter int width_p    = 16,
  parameter int lg_width_p = (width_p <= 1) ? 1 : $clog2(width_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [width_p-1:0]    reqs_i,
  output logic [width_p-1:0]    grants_o,
  output logic [lg_width_p-1:0] sel_id_o,
  output logic                  v_o,
  input  logic                  yumi_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                state_reg, state_next;
  logic [width_p-1:0]    grants_reg, grants_next;
  logic [lg_width_p-1:0] sel_reg, sel_next;
  logic [lg_width_p-1:0] last_reg, last_next;

  logic [width_p-1:0]    cand;
  logic [lg_width_p-1:0] ptr;
  logic [width_p-1:0]    mask;
  logic [width_p-1:0]    pick;
  logic [width_p-1:0]    win_oh;
  logic [lg_width_p-1:0] win_id;

  // On a yumi regrant the current winner is excluded and the pointer is the
  // winner being retired, so back-to-back grants already see rotated priority.
  assign cand = (state_reg == BUSY) ? (reqs_i & ~grants_reg) : reqs_i;
  assign ptr  = (state_reg == BUSY) ? sel_reg : last_reg;

  for (genvar gi = 0; gi < width_p; gi++) begin : g_mask
    assign mask[gi] = (lg_width_p'(gi) > ptr);
  end

  assign pick = (|(cand & mask)) ? (cand & mask) : cand;

  always_comb begin
    win_oh = '0;
    win_id = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (pick[k]) begin
        win_oh    = '0;
        win_oh[k] = 1'b1;
        win_id    = lg_width_p'(k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg  <= IDLE;
      grants_reg <= '0;
      sel_reg    <= '0;
      last_reg   <= lg_width_p'(width_p - 1);
    end else begin
      state_reg  <= state_next;
      grants_reg <= grants_next;
      sel_reg    <= sel_next;
      last_reg   <= last_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grants_next = grants_reg;
    sel_next    = sel_reg;
    last_next   = last_reg;
    case (state_reg)
      IDLE: begin
        if (|cand) begin
          state_next  = BUSY;
          grants_next = win_oh;
          sel_next    = win_id;
        end
      end
      BUSY: begin
        if (yumi_i) begin
          last_next = sel_reg;
          if (|cand) begin
            grants_next = win_oh;
            sel_next    = win_id;
          end else begin
            state_next  = IDLE;
            grants_next = '0;
            sel_next    = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    v_o      = (state_reg == BUSY);
    grants_o = grants_reg;
    sel_id_o = sel_reg;
  end

  a_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grants_o));
  a_valid:  assert property (@(posedge clk_i) disable iff (reset_i) v_o == (|grants_o));
  a_yumi:   assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_arb_round_robin_hold.sv
// Directed table-driven bench for bsg_arb_round_robin_hold (width_p=16).
module tb_bsg_arb_round_robin_hold;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] reqs_i;
  logic [15:0] grants_o;
  logic [3:0]  sel_id_o;
  logic        v_o;
  logic        yumi_i;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_arb_round_robin_hold #(.width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .reqs_i(reqs_i),
    .grants_o(grants_o), .sel_id_o(sel_id_o), .v_o(v_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [15:0] reqs;
    logic        yumi;
    logic [15:0] g;
    logic [3:0]  sel;
    logic        v;
  } vec_t;

  vec_t vecs[80];
  int   n_vecs = 0;

  task automatic add(input logic rst, input logic [15:0] reqs, input logic yumi,
                     input logic [15:0] g, input logic [3:0] sel, input logic v);
    vecs[n_vecs] = '{rst, reqs, yumi, g, sel, v};
    n_vecs++;
  endtask

  // Drive inputs on the falling edge, sample #1 after the next rising edge.
  task automatic step(input string name, input logic rst, input logic [15:0] reqs,
                      input logic yumi, input logic [15:0] g, input logic [3:0] sel,
                      input logic v);
    @(negedge clk_i);
    reset_i = rst; reqs_i = reqs; yumi_i = yumi;
    @(posedge clk_i);
    #1;
    n_checks++;
    if (grants_o !== g || sel_id_o !== sel || v_o !== v) begin
      n_fail++;
      $display("FAIL %s: got grants=%h sel=%0d v=%b, expected grants=%h sel=%0d v=%b",
               name, grants_o, sel_id_o, v_o, g, sel, v);
    end else begin
      $display("ok   %s: reqs=%h yumi=%b -> grants=%h sel=%0d v=%b",
               name, reqs, yumi, grants_o, sel_id_o, v_o);
    end
  endtask

  initial begin
    reset_i = 1'b1; reqs_i = '0; yumi_i = 1'b0;

    // Reset and idle
    add(1, 16'h0000, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 0, 16'h0000, 0, 0);
    // Two requesters alternate with no bubble
    add(0, 16'h8001, 0, 16'h0001, 0, 1);
    add(0, 16'h8001, 1, 16'h8000, 15, 1);
    add(0, 16'h8001, 1, 16'h0001, 0, 1);
    add(0, 16'h8001, 1, 16'h8000, 15, 1);
    add(0, 16'h0000, 1, 16'h0000, 0, 0);
    // Grant holds while yumi is low, even as reqs change
    add(0, 16'h0010, 0, 16'h0010, 4, 1);
    add(0, 16'h0010, 0, 16'h0010, 4, 1);
    add(0, 16'h0100, 0, 16'h0010, 4, 1);
    add(0, 16'h0100, 0, 16'h0010, 4, 1);
    add(0, 16'h0000, 0, 16'h0010, 4, 1);
    add(0, 16'h0000, 1, 16'h0000, 0, 0);
    // last=4: bit 5 beats bit 0, then wrap to bit 0
    add(0, 16'h0031, 0, 16'h0020, 5, 1);
    add(0, 16'h0031, 1, 16'h0001, 0, 1);
    add(0, 16'h0000, 1, 16'h0000, 0, 0);
    // Full walk from reset
    add(1, 16'hFFFF, 0, 16'h0000, 0, 0);
    add(0, 16'hFFFF, 0, 16'h0001, 0, 1);
    for (int i = 1; i <= 16; i++) add(0, 16'hFFFF, 1, 16'h0001 << (i % 16), 4'(i % 16), 1);
    add(0, 16'h0000, 1, 16'h0000, 0, 0);
    // Single requester: grant / idle / grant
    for (int i = 0; i < 3; i++) begin
      add(0, 16'h0004, 0, 16'h0004, 2, 1);
      add(0, 16'h0004, 1, 16'h0000, 0, 0);
    end

    for (int i = 0; i < n_vecs; i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].reqs, vecs[i].yumi,
           vecs[i].g, vecs[i].sel, vecs[i].v);

    // Reset while busy drops the grant and restores last to 15
    step("rb_setup", 0, 16'h0200, 0, 16'h0200, 9, 1);
    step("rb_reset", 1, 16'h0200, 1, 16'h0000, 0, 0);
    step("rb_first", 0, 16'h0201, 0, 16'h0001, 0, 1);
    step("rb_next",  0, 16'h0201, 1, 16'h0200, 9, 1);
    step("rb_hold",  0, 16'h0000, 0, 16'h0200, 9, 1);
    step("rb_done",  0, 16'h0000, 1, 16'h0000, 0, 0);

    // Dropped holder is excluded; remaining requester after rotation
    step("ex_setup", 0, 16'h0003, 0, 16'h0001, 0, 1);
    step("ex_rot",   0, 16'h0003, 1, 16'h0002, 1, 1);
    step("ex_wrap",  0, 16'h0003, 1, 16'h0001, 0, 1);
    step("ex_idle",  0, 16'h0000, 1, 16'h0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
